// File: rtl/fifo_rd_burst_sched.sv
// fifo_rd_burst_sched: groups FWFT FIFO reads into bursts on a registered valid/ready stream,
// flushing a partial burst after TIMEOUT idle cycles.
module fifo_rd_burst_sched #(
  parameter int RD_WIDTH     = 32,
  parameter int RD_CNT_WIDTH = 4,
  parameter int BURST_LEN    = 4,
  parameter int TIMEOUT      = 16,
  parameter int TO_WIDTH     = 5
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst_n,
  input  logic                    fifo_empty,
  input  logic [RD_CNT_WIDTH-1:0] rd_data_count,
  input  logic [RD_WIDTH-1:0]     fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic                    m_valid,
  output logic [RD_WIDTH-1:0]     m_data,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    burst_active,
  output logic                    flush_burst
);
  typedef enum logic [1:0] {IDLE, BURST, TAIL} state_t;
  localparam logic [RD_CNT_WIDTH-1:0] BL      = RD_CNT_WIDTH'(BURST_LEN);
  localparam logic [TO_WIDTH-1:0]     TO_LAST = TO_WIDTH'(TIMEOUT - 1);
  state_t                  state;
  logic [TO_WIDTH-1:0]     timer;
  logic [RD_CNT_WIDTH-1:0] beat, blen;
  logic                    pop, full, inc, last_beat;
  assign pop        = (state == BURST) && !fifo_empty && (!m_valid || m_ready);
  assign fifo_rd_en = pop;
  assign full       = rd_data_count >= BL;
  assign inc        = !fifo_empty && !full;
  assign last_beat  = beat == blen - RD_CNT_WIDTH'(1);
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      beat         <= '0;
      blen         <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      burst_active <= 1'b0;
      flush_burst  <= 1'b0;
    end else begin
      if (pop) begin
        m_data  <= fifo_rd_data;
        m_valid <= 1'b1;
        m_last  <= last_beat;
        beat    <= beat + RD_CNT_WIDTH'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (full) begin
            state        <= BURST;
            blen         <= BL;
            beat         <= '0;
            flush_burst  <= 1'b0;
            timer        <= '0;
            burst_active <= 1'b1;
          end else if (inc && timer == TO_LAST) begin
            state        <= BURST;
            blen         <= rd_data_count;
            beat         <= '0;
            flush_burst  <= 1'b1;
            timer        <= '0;
            burst_active <= 1'b1;
          end else if (inc) begin
            timer <= timer + TO_WIDTH'(1);
          end else begin
            timer <= '0;
          end
        end
        BURST: if (pop && last_beat) state <= TAIL;
        TAIL: begin
          if (m_valid && m_last && m_ready) begin
            state        <= IDLE;
            burst_active <= 1'b0;
            flush_burst  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_burst_sched.sv
// tb_fifo_rd_burst_sched: directed checks of the burst scheduler against a small FWFT FIFO model.
module tb_fifo_rd_burst_sched;
  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        fifo_empty;
  logic [3:0]  rd_data_count;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        burst_active;
  logic        flush_burst;
  logic [31:0] mem [0:63];
  logic [31:0] acc [0:63];
  int          head = 0, tail = 0, pops = 0, acc_n = 0, viol = 0;
  logic        force_empty = 1'b0;
  int          errors = 0, checks = 0;
  int          p0, a0;
  logic [31:0] g [0:3];

  fifo_rd_burst_sched dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
    .rd_data_count(rd_data_count), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .burst_active(burst_active), .flush_burst(flush_burst)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty    = force_empty || (tail == head);
  assign rd_data_count = 4'(tail - head);
  assign fifo_rd_data  = mem[head % 64];

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) head <= tail;
    else begin
      if (fifo_rd_en) begin
        head <= head + 1;
        pops <= pops + 1;
        if (fifo_empty) viol <= viol + 1;
      end
      if (m_valid && m_ready) begin
        acc[acc_n % 64] <= m_data;
        acc_n <= acc_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    mem[tail % 64] = d;
    tail = tail + 1;
  endtask

  task automatic tick();
    @(negedge rd_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_active", 32'(burst_active), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_data", m_data, 0);
    rd_rst_n = 1'b1;
    tick();

    // full burst
    p0 = pops;
    push(32'hA); push(32'hB); push(32'hC); push(32'hD);
    tick();
    check("full_active", 32'(burst_active), 1);
    check("full_flush", 32'(flush_burst), 0);
    check("full_rd_en", 32'(fifo_rd_en), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_data", m_data, 32'hA + 32'(i));
      check("full_valid", 32'(m_valid), 1);
      check("full_last", 32'(m_last), 32'(i == 3));
    end
    check("full_tail_rd_en", 32'(fifo_rd_en), 0);
    tick();
    check("full_done_active", 32'(burst_active), 0);
    check("full_done_valid", 32'(m_valid), 0);
    check("full_pops", 32'(pops - p0), 4);

    // timeout flush
    p0 = pops;
    push(32'hE0); push(32'hE1);
    repeat (15) tick();
    check("to_not_yet", 32'(burst_active), 0);
    tick();
    check("to_active", 32'(burst_active), 1);
    check("to_flush", 32'(flush_burst), 1);
    tick();
    check("to_d0", m_data, 32'hE0);
    check("to_last0", 32'(m_last), 0);
    tick();
    check("to_d1", m_data, 32'hE1);
    check("to_last1", 32'(m_last), 1);
    check("to_flush_hold", 32'(flush_burst), 1);
    tick();
    check("to_done_active", 32'(burst_active), 0);
    check("to_done_flush", 32'(flush_burst), 0);
    check("to_pops", 32'(pops - p0), 2);

    // backpressure
    g[0] = 32'h100; g[1] = 32'h101; g[2] = 32'h102; g[3] = 32'h103;
    p0 = pops; a0 = acc_n;
    for (int i = 0; i < 4; i++) push(g[i]);
    tick();
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", m_data, g[0]);
      check("bp_hold_valid", 32'(m_valid), 1);
      check("bp_rd_en", 32'(fifo_rd_en), 0);
      if (i < 4) tick();
    end
    check("bp_pops", 32'(pops - p0), 1);
    m_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("bp_data", m_data, g[i]);
      check("bp_last", 32'(m_last), 32'(i == 3));
    end
    tick();
    check("bp_done_active", 32'(burst_active), 0);
    check("bp_acc_n", 32'(acc_n - a0), 4);
    for (int i = 0; i < 4; i++) check("bp_acc", acc[(a0 + i) % 64], g[i]);

    // empty mid-burst
    p0 = pops;
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
    tick();
    tick();
    tick();
    check("em_d1", m_data, 32'h201);
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("em_rd_en", 32'(fifo_rd_en), 0);
      tick();
    end
    force_empty = 1'b0;
    check("em_pops", 32'(pops - p0), 2);
    check("em_active", 32'(burst_active), 1);
    check("em_valid", 32'(m_valid), 0);
    tick();
    check("em_d2", m_data, 32'h202);
    check("em_last2", 32'(m_last), 0);
    tick();
    check("em_d3", m_data, 32'h203);
    check("em_last3", 32'(m_last), 1);
    tick();
    check("em_done_active", 32'(burst_active), 0);

    // priority: count reaches BURST_LEN exactly as the timer hits its limit
    p0 = pops;
    push(32'h300); push(32'h301);
    repeat (15) tick();
    check("pr_idle", 32'(burst_active), 0);
    push(32'h302); push(32'h303);
    tick();
    check("pr_active", 32'(burst_active), 1);
    check("pr_flush", 32'(flush_burst), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pr_data", m_data, 32'h300 + 32'(i));
      check("pr_last", 32'(m_last), 32'(i == 3));
    end
    tick();
    check("pr_pops", 32'(pops - p0), 4);

    // reset mid-burst
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i));
    tick();
    tick();
    tick();
    check("rm_d1", m_data, 32'h401);
    rd_rst_n = 1'b0;
    #1;
    check("rm_valid", 32'(m_valid), 0);
    check("rm_data", m_data, 0);
    check("rm_last", 32'(m_last), 0);
    check("rm_active", 32'(burst_active), 0);
    check("rm_flush", 32'(flush_burst), 0);
    check("rm_rd_en", 32'(fifo_rd_en), 0);
    tick();
    tick();
    rd_rst_n = 1'b1;
    tick();
    check("rm_post_active", 32'(burst_active), 0);
    push(32'h500);
    repeat (15) tick();
    check("rm_timer_idle", 32'(burst_active), 0);
    tick();
    check("rm_timer_flush", 32'(flush_burst), 1);
    tick();
    check("rm_d", m_data, 32'h500);
    check("rm_single_last", 32'(m_last), 1);
    tick();
    check("rm_done", 32'(burst_active), 0);
    check("no_pop_when_empty", 32'(viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
